// File: rtl/data_bus_responder.sv
// data_bus_responder
//
// Single-port byte-addressed data memory behind a valid/ready request and
// response handshake, as seen from an RV32I load/store unit. One transaction
// may be outstanding. The request is captured on acceptance, then a programmable
// number of wait states elapse before the response is presented.
//
// Parameters:
//   Memory_Size - storage size in bytes
//   WAIT_CYCLES - wait states between acceptance and response (0..15)
//
// Ports:
//   clk        - clock, rising edge
//   reset      - asynchronous, active-low reset
//   Req_Valid  - initiator presents a request
//   Req_Ready  - responder is idle and can accept a request
//   Req_Store  - 1 = store, 0 = load
//   Req_Addr   - byte address
//   Req_Func_3 - RV32I size/sign code (000 b, 001 h, 010 w, 100 bu, 101 hu)
//   Req_Wdata  - store data, right-aligned
//   Rsp_Valid  - response available
//   Rsp_Ready  - initiator accepts the response
//   Rsp_Rdata  - load result, sign/zero extended; 0 for stores and errors
//   Rsp_Error  - access was rejected (illegal code, out of range, misaligned)
//
// Configuration macro:
//   DBUS_ALIGN_CHECK_EN - defined: misaligned half/word accesses are errors.
//                         undefined: low address bits are forced to natural
//                         alignment and misalignment is never an error.

module data_bus_responder #(
  parameter int Memory_Size = 152,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Req_Valid,
  output logic        Req_Ready,
  input  logic        Req_Store,
  input  logic [31:0] Req_Addr,
  input  logic [2:0]  Req_Func_3,
  input  logic [31:0] Req_Wdata,
  output logic        Rsp_Valid,
  input  logic        Rsp_Ready,
  output logic [31:0] Rsp_Rdata,
  output logic        Rsp_Error
);

  localparam int AW = (Memory_Size > 1) ? $clog2(Memory_Size) : 1;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic        store_q;
  logic [31:0] addr_q;
  logic [2:0]  func_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic        error_q;
  logic [7:0]  mem_q [Memory_Size];

  logic        accept;
  logic        enterResp;
  logic        selStore;
  logic [31:0] selAddr;
  logic [2:0]  selFunc;
  logic [31:0] selWdata;
  logic [2:0]  sizeBytes;
  logic        illegal;
  logic        misaligned;
  logic [31:0] effAddr;
  logic [32:0] endAddr;
  logic        outOfRange;
  logic        accessErr;
  logic [AW-1:0] baseIdx;
  logic [31:0] rawData;
  logic [31:0] loadExt;
  logic [31:0] rdata_d;
  logic        error_d;

  assign accept    = (state_q == IDLE) && Req_Valid;
  assign enterResp = (accept && (WAIT_CYCLES == 0)) ||
                     ((state_q == WAIT) && (cnt_q == 4'd1));

  // With zero wait states the access completes on the acceptance edge itself,
  // so the decode must see the live request rather than the captured copy.
  always_comb begin
    if (state_q == IDLE) begin
      selStore = Req_Store;
      selAddr  = Req_Addr;
      selFunc  = Req_Func_3;
      selWdata = Req_Wdata;
    end else begin
      selStore = store_q;
      selAddr  = addr_q;
      selFunc  = func_q;
      selWdata = wdata_q;
    end
  end

  // Decode size, legality, alignment and range of the selected access.
  // The range test uses 33 bits so addresses near 2^32 cannot wrap to zero.
  always_comb begin
    sizeBytes  = 3'd1;
    illegal    = 1'b0;
    misaligned = 1'b0;
    effAddr    = selAddr;
    case (selFunc[1:0])
      2'b00:   sizeBytes = 3'd1;
      2'b01:   sizeBytes = 3'd2;
      2'b10:   sizeBytes = 3'd4;
      default: begin
        sizeBytes = 3'd4;
        illegal   = 1'b1;
      end
    endcase
    if (selFunc[2] && (selFunc[1] || selStore)) begin
      illegal = 1'b1;
    end
`ifdef DBUS_ALIGN_CHECK_EN
    misaligned = ((sizeBytes == 3'd2) && selAddr[0]) ||
                 ((sizeBytes == 3'd4) && (selAddr[1:0] != 2'b00));
`else
    if (sizeBytes == 3'd2) begin
      effAddr[0] = 1'b0;
    end
    if (sizeBytes == 3'd4) begin
      effAddr[1:0] = 2'b00;
    end
`endif
    endAddr    = {1'b0, effAddr} + {30'd0, sizeBytes};
    outOfRange = endAddr > 33'(Memory_Size);
    accessErr  = illegal || misaligned || outOfRange;
  end

  assign baseIdx = effAddr[AW-1:0];

  // Gather the addressed bytes little-endian, then sign or zero extend.
  always_comb begin
    rawData = '0;
    if (!accessErr) begin
      for (int i = 0; i < 4; i++) begin
        if (3'(i) < sizeBytes) begin
          rawData[8*i +: 8] = mem_q[baseIdx + AW'(i)];
        end
      end
    end
    case (selFunc)
      3'b000:  loadExt = {{24{rawData[7]}}, rawData[7:0]};
      3'b001:  loadExt = {{16{rawData[15]}}, rawData[15:0]};
      3'b100:  loadExt = {24'd0, rawData[7:0]};
      3'b101:  loadExt = {16'd0, rawData[15:0]};
      default: loadExt = rawData;
    endcase
    rdata_d = (accessErr || selStore) ? 32'd0 : loadExt;
    error_d = accessErr;
  end

  // FSM, request capture, response registers and memory. The store commit and
  // the load read both happen on the edge entering RESP, so a reset during
  // WAIT discards a pending store entirely.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      store_q <= 1'b0;
      addr_q  <= 32'd0;
      func_q  <= 3'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      error_q <= 1'b0;
      for (int i = 0; i < Memory_Size; i++) begin
        mem_q[i] <= 8'd0;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (Req_Valid) begin
            store_q <= Req_Store;
            addr_q  <= Req_Addr;
            func_q  <= Req_Func_3;
            wdata_q <= Req_Wdata;
            cnt_q   <= 4'(WAIT_CYCLES);
            state_q <= (WAIT_CYCLES == 0) ? RESP : WAIT;
          end
        end
        WAIT: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_q <= RESP;
          end
        end
        RESP: begin
          if (Rsp_Ready) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
      if (enterResp) begin
        rdata_q <= rdata_d;
        error_q <= error_d;
        if (selStore && !accessErr) begin
          for (int i = 0; i < 4; i++) begin
            if (3'(i) < sizeBytes) begin
              mem_q[baseIdx + AW'(i)] <= selWdata[8*i +: 8];
            end
          end
        end
      end
    end
  end

  assign Req_Ready = (state_q == IDLE);
  assign Rsp_Valid = (state_q == RESP);
  assign Rsp_Rdata = rdata_q;
  assign Rsp_Error = error_q;

endmodule
